// File: rtl/mux_pipe_n.sv
// Pipelined M:1 word select built as a radix-4 tree, one register per tree level.
// Latency L = ceil(ADDR_W/2) cycles from accept to valid_o; one item per cycle sustained.
// Global stall: ready_o = ~valid_o | ready_i, and every stage holds while it is low.
module mux_pipe_n #(
    parameter int n      = 4,
    parameter int ADDR_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [n-1:0]      data_i [0:(2**ADDR_W)-1],
    input  logic [ADDR_W-1:0] sel_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [n-1:0]      data_o,
    output logic [ADDR_W-1:0] sel_o
);

    localparam int L = (ADDR_W + 1) / 2;

    // One shared advance for the whole pipe; bubbles are never squeezed out.
    logic adv;

    assign adv     = ~valid_o | ready_i;
    assign ready_o = adv;

    // Level 0 is the raw input; level k holds M/4**k words (1 word at level L).
    for (genvar k = 0; k <= L; k++) begin : g_lvl
        localparam int NW = 2 ** (ADDR_W - ((2 * k > ADDR_W) ? ADDR_W : 2 * k));

        logic [n-1:0]      dat [NW];
        logic [ADDR_W-1:0] sel;
        logic              vld;

        if (k == 0) begin : g_in
            assign dat = data_i;
            assign sel = sel_i;
            assign vld = valid_i;
        end else begin : g_reg
            // Select bits still to be resolved when entering this level.
            localparam int REM = ADDR_W - 2 * (k - 1);

            logic [n-1:0] nxt [NW];

            if (REM >= 2) begin : g_r4
                logic [n-1:0] pdat [4*NW];
                logic [1:0]   s;

                assign pdat = g_lvl[k-1].dat;
                assign s    = g_lvl[k-1].sel[2*k-1 -: 2];

                // 4:1 pick inside each group of four consecutive words.
                always_comb begin
                    for (int j = 0; j < NW; j++) begin
                        nxt[j] = pdat[4*j];
                        for (int r = 1; r < 4; r++) begin
                            if (s == 2'(r)) nxt[j] = pdat[4*j+r];
                        end
                    end
                end
            end else begin : g_r2
                logic [n-1:0] pdat [2*NW];
                logic         s;

                assign pdat = g_lvl[k-1].dat;
                assign s    = g_lvl[k-1].sel[ADDR_W-1];

                // Odd select width: the last level only needs a 2:1 pick on the top bit.
                always_comb begin
                    for (int j = 0; j < NW; j++) begin
                        nxt[j] = s ? pdat[2*j+1] : pdat[2*j];
                    end
                end
            end

            // Stage register: flush kills valid regardless of stall; data and tag move on adv.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld <= 1'b0;
                    sel <= '0;
                    for (int j = 0; j < NW; j++) dat[j] <= '0;
                end else begin
                    if (flush_i) begin
                        vld <= 1'b0;
                    end else if (adv) begin
                        vld <= g_lvl[k-1].vld;
                    end
                    if (adv) begin
                        sel <= g_lvl[k-1].sel;
                        dat <= nxt;
                    end
                end
            end
        end
    end

    assign valid_o = g_lvl[L].vld;
    assign data_o  = g_lvl[L].dat[0];
    assign sel_o   = g_lvl[L].sel;

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed bench for mux_pipe_n: 128:1 instance (L=4) plus a 32:1 instance (L=3).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A scoreboard on the 128:1 instance checks order/loss/duplication on every output handshake.
module tb_mux_pipe_n;

    logic       clk;
    logic       rst_ni;
    logic       flush_i;
    logic       valid_i;
    logic       ready_o;
    logic [3:0] data_i [0:127];
    logic [6:0] sel_i;
    logic       valid_o;
    logic       ready_i;
    logic [3:0] data_o;
    logic [6:0] sel_o;

    logic       valid5;
    logic       ready5_o;
    logic [3:0] data5 [0:31];
    logic [4:0] sel5;
    logic       valid5_o;
    logic [3:0] data5_o;
    logic [4:0] sel5_o;

    int n_chk  = 0;
    int n_pass = 0;

    logic [10:0] sb_q [$];

    mux_pipe_n #(.n(4), .ADDR_W(7)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .sel_i   (sel_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .sel_o   (sel_o)
    );

    mux_pipe_n #(.n(4), .ADDR_W(5)) dut5 (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .valid_i (valid5),
        .ready_o (ready5_o),
        .data_i  (data5),
        .sel_i   (sel5),
        .valid_o (valid5_o),
        .ready_i (1'b1),
        .data_o  (data5_o),
        .sel_o   (sel5_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on output handshake, push on accept, drop everything on flush/reset.
    always @(negedge clk) begin
        if (!rst_ni) begin
            sb_q.delete();
        end else begin
            if (valid_o && ready_i) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected", 32'(sb_q.size()), 1);
                end else begin
                    logic [10:0] e;
                    e = sb_q.pop_front();
                    check("sb_sel", 32'(sel_o), 32'(e[10:4]));
                    check("sb_dat", 32'(data_o), 32'(e[3:0]));
                end
            end
            if (valid_i && ready_o && !flush_i) sb_q.push_back({sel_i, data_i[sel_i]});
            if (flush_i) sb_q.delete();
        end
    end

    initial begin
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        sel_i   = '0;
        valid5  = 1'b0;
        sel5    = '0;
        for (int k = 0; k < 128; k++) data_i[k] = 4'(k) ^ 4'hA;
        for (int k = 0; k < 32; k++)  data5[k]  = 4'(k) ^ 4'hA;

        // Reset state
        #2;
        check("rst_vld", 32'(valid_o), 0);
        check("rst_dat", 32'(data_o), 0);
        check("rst_sel", 32'(sel_o), 0);
        #20;
        nxt(); rst_ni = 1'b1;
        @(negedge clk);
        check("rel_rdy", 32'(ready_o), 1);
        check("rel_vld", 32'(valid_o), 0);

        // Full sweep, no stall: first output 4 cycles in, then back-to-back
        for (int c = 0; c < 133; c++) begin
            nxt();
            if (c < 128) begin
                valid_i = 1'b1;
                sel_i   = 7'(c);
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk);
            check("sweep_vld", 32'(valid_o), (c >= 4 && c < 132) ? 1 : 0);
            if (c >= 4 && c < 132) begin
                check("sweep_sel", 32'(sel_o), 32'(c - 4));
                check("sweep_dat", 32'(data_o), 32'(4'(c - 4) ^ 4'hA));
            end
        end

        // Stall for two cycles with sel 5 on the output
        nxt(); valid_i = 1'b1; sel_i = 7'd5; @(negedge clk);
        nxt(); sel_i = 7'd6; @(negedge clk);
        nxt(); sel_i = 7'd7; @(negedge clk);
        nxt(); sel_i = 7'd8; @(negedge clk);
        nxt(); valid_i = 1'b0; ready_i = 1'b0; @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("stall_vld", 32'(valid_o), 1);
            check("stall_sel", 32'(sel_o), 5);
            check("stall_dat", 32'(data_o), 32'h0F);
            check("stall_rdy", 32'(ready_o), 0);
            if (i == 0) begin
                nxt(); @(negedge clk);
            end
        end
        nxt(); ready_i = 1'b1; @(negedge clk);
        check("unstall_sel5", 32'(sel_o), 5);
        check("unstall_rdy", 32'(ready_o), 1);
        nxt(); @(negedge clk);
        check("unstall_sel6", 32'(sel_o), 6);
        check("unstall_dat6", 32'(data_o), 32'h0C);
        nxt(); @(negedge clk);
        check("unstall_sel7", 32'(sel_o), 7);
        check("unstall_dat7", 32'(data_o), 32'h0D);
        nxt(); @(negedge clk);
        check("unstall_sel8", 32'(sel_o), 8);
        check("unstall_dat8", 32'(data_o), 32'h02);
        nxt(); @(negedge clk);
        check("unstall_end", 32'(valid_o), 0);

        // Input snapshot: data_i changes after accept must not leak through
        nxt(); valid_i = 1'b1; sel_i = 7'd127; data_i[127] = 4'h3; @(negedge clk);
        nxt(); valid_i = 1'b0; data_i[127] = 4'hC; @(negedge clk);
        check("snap_vld1", 32'(valid_o), 0);
        nxt(); @(negedge clk);
        nxt(); @(negedge clk);
        check("snap_vld3", 32'(valid_o), 0);
        nxt(); @(negedge clk);
        check("snap_vld4", 32'(valid_o), 1);
        check("snap_sel", 32'(sel_o), 127);
        check("snap_dat", 32'(data_o), 32'h3);
        data_i[127] = 4'h5;
        nxt(); @(negedge clk);

        // Flush with three items in flight plus one offered on the flush cycle
        nxt(); valid_i = 1'b1; sel_i = 7'd10; @(negedge clk);
        nxt(); sel_i = 7'd11; @(negedge clk);
        nxt(); sel_i = 7'd12; @(negedge clk);
        nxt(); flush_i = 1'b1; sel_i = 7'd20; @(negedge clk);
        check("flush_rdy", 32'(ready_o), 1);
        nxt(); flush_i = 1'b0; sel_i = 7'd30; @(negedge clk);
        check("flush_vld0", 32'(valid_o), 0);
        nxt(); valid_i = 1'b0; @(negedge clk);
        check("flush_vld1", 32'(valid_o), 0);
        nxt(); @(negedge clk);
        check("flush_vld2", 32'(valid_o), 0);
        nxt(); @(negedge clk);
        check("flush_vld3", 32'(valid_o), 0);
        nxt(); @(negedge clk);
        check("post_flush_vld", 32'(valid_o), 1);
        check("post_flush_sel", 32'(sel_o), 30);
        check("post_flush_dat", 32'(data_o), 32'h4);
        nxt(); @(negedge clk);
        check("post_flush_end", 32'(valid_o), 0);

        // Odd select width: 32:1, three levels
        nxt(); valid5 = 1'b1; sel5 = 5'd31; @(negedge clk);
        nxt(); sel5 = 5'd16; @(negedge clk);
        nxt(); valid5 = 1'b0; @(negedge clk);
        check("odd_vld2", 32'(valid5_o), 0);
        nxt(); @(negedge clk);
        check("odd_vld31", 32'(valid5_o), 1);
        check("odd_sel31", 32'(sel5_o), 31);
        check("odd_dat31", 32'(data5_o), 32'h5);
        nxt(); @(negedge clk);
        check("odd_sel16", 32'(sel5_o), 16);
        check("odd_dat16", 32'(data5_o), 32'hA);
        check("odd_rdy", 32'(ready5_o), 1);
        nxt(); @(negedge clk);
        check("odd_end", 32'(valid5_o), 0);

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 6; i++) begin
            nxt(); valid_i = 1'b1; sel_i = 7'(40 + i); @(negedge clk);
        end
        check("pre_rst_vld", 32'(valid_o), 1);
        nxt(); valid_i = 1'b0; #1; rst_ni = 1'b0; #1;
        check("mid_rst_vld", 32'(valid_o), 0);
        check("mid_rst_dat", 32'(data_o), 0);
        check("mid_rst_sel", 32'(sel_o), 0);
        @(negedge clk);
        nxt(); rst_ni = 1'b1; @(negedge clk);
        check("mid_rel_rdy", 32'(ready_o), 1);
        check("mid_rel_vld", 32'(valid_o), 0);
        for (int i = 0; i < 5; i++) begin
            nxt(); @(negedge clk);
        end
        check("post_rst_quiet", 32'(valid_o), 0);

        check("sb_drain", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
